// File: rtl/pipe_rx_data_packer_if.sv
// pipe_rx_data_packer_if: decoded-symbol input and packed PIPE RxData output bundle.
interface pipe_rx_data_packer_if #(parameter int MAX_WIDTH = 32);
  logic [1:0]             width_sel;
  logic                   sym_valid;
  logic [7:0]             sym_data;
  logic                   sym_k;
  logic                   sym_align;
  logic [MAX_WIDTH-1:0]   rx_data;
  logic [MAX_WIDTH/8-1:0] rx_datak;
  logic                   rx_valid;
  logic [1:0]             cur_width;
  logic [7:0]             drop_cnt;
  modport master (
    output width_sel, sym_valid, sym_data, sym_k, sym_align,
    input  rx_data, rx_datak, rx_valid, cur_width, drop_cnt
  );
  modport slave (
    input  width_sel, sym_valid, sym_data, sym_k, sym_align,
    output rx_data, rx_datak, rx_valid, cur_width, drop_cnt
  );
endinterface

// File: rtl/pipe_rx_data_packer.sv
// pipe_rx_data_packer: packs one decoded symbol per clock into an 8/16/32-bit PIPE RxData word.
module pipe_rx_data_packer #(
  parameter int MAX_WIDTH = 32
) (
  input logic                 pclk,
  input logic                 reset_n,
  pipe_rx_data_packer_if.slave bus
);
  localparam int LANES = MAX_WIDTH / 8;
  logic [1:0]           lane_q, lane_d, cur_width_q, cur_width_d, width_req, lane_wr, lane_last;
  logic [MAX_WIDTH-1:0] stage_q, stage_d, rx_data_q, rx_data_d, lane_mask_bits;
  logic [LANES-1:0]     stage_k_q, stage_k_d, rx_datak_q, rx_datak_d, lane_mask;
  logic                 rx_valid_q, rx_valid_d, drop, last;
  logic [7:0]           drop_cnt_q, drop_cnt_d;
  always_comb begin
    width_req = (bus.width_sel == 2'd3) ? 2'd2 : bus.width_sel;
    // width is only re-sampled between words so a word never straddles two widths
    cur_width_d = (lane_q == 2'd0) ? width_req : cur_width_q;
    lane_last = (cur_width_d == 2'd0) ? 2'd0 : (cur_width_d == 2'd1) ? 2'd1 : 2'd3;
    lane_mask = (cur_width_d == 2'd0) ? 4'b0001 : (cur_width_d == 2'd1) ? 4'b0011 : 4'b1111;
    drop = bus.sym_align && (lane_q != 2'd0);
    lane_wr = drop ? 2'd0 : lane_q;
    last = bus.sym_valid && (lane_wr == lane_last);
    stage_d = stage_q;
    stage_k_d = stage_k_q;
    lane_mask_bits = '0;
    for (int i = 0; i < LANES; i++) begin
      stage_d[8*i +: 8] = (bus.sym_valid && lane_wr == 2'(i)) ? bus.sym_data : stage_q[8*i +: 8];
      stage_k_d[i] = (bus.sym_valid && lane_wr == 2'(i)) ? bus.sym_k : stage_k_q[i];
      lane_mask_bits[8*i +: 8] = {8{lane_mask[i]}};
    end
    rx_valid_d = last;
    // stale bytes from wider earlier words sit in unused lanes; mask them off
    rx_data_d = last ? (stage_d & lane_mask_bits) : rx_data_q;
    rx_datak_d = last ? (stage_k_d & lane_mask) : rx_datak_q;
    lane_d = !bus.sym_valid ? lane_wr : last ? 2'd0 : lane_wr + 2'd1;
    drop_cnt_d = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end
  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      lane_q <= 2'd0;
      cur_width_q <= width_req;
      stage_q <= '0;
      stage_k_q <= '0;
      rx_data_q <= '0;
      rx_datak_q <= '0;
      rx_valid_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      lane_q <= lane_d;
      cur_width_q <= cur_width_d;
      stage_q <= stage_d;
      stage_k_q <= stage_k_d;
      rx_data_q <= rx_data_d;
      rx_datak_q <= rx_datak_d;
      rx_valid_q <= rx_valid_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
  assign bus.rx_data = rx_data_q;
  assign bus.rx_datak = rx_datak_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.cur_width = cur_width_q;
  assign bus.drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_pipe_rx_data_packer.sv
// tb_pipe_rx_data_packer: directed-vector bench for the receive gearbox.
module tb_pipe_rx_data_packer;
  logic pclk = 1'b0;
  logic reset_n = 1'b0;
  int passed = 0;
  int total = 0;
  pipe_rx_data_packer_if #(.MAX_WIDTH(32)) bus ();
  pipe_rx_data_packer #(.MAX_WIDTH(32)) dut (.pclk(pclk), .reset_n(reset_n), .bus(bus));
  always #5 pclk = ~pclk;
  task automatic drive(input logic v, input logic [7:0] d, input logic k, input logic a);
    @(negedge pclk);
    bus.sym_valid = v;
    bus.sym_data = d;
    bus.sym_k = k;
    bus.sym_align = a;
    @(posedge pclk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic chk_word(input string tag, input logic [31:0] d, input logic [3:0] k);
    chk({tag, " valid"}, 32'(bus.rx_valid), 32'd1);
    chk({tag, " data"}, bus.rx_data, d);
    chk({tag, " datak"}, 32'(bus.rx_datak), 32'(k));
  endtask
  initial begin
    bus.width_sel = 2'd2;
    bus.sym_valid = 1'b0;
    bus.sym_data = 8'h00;
    bus.sym_k = 1'b0;
    bus.sym_align = 1'b0;
    // reset
    drive(0, 8'h00, 0, 0);
    drive(0, 8'h00, 0, 0);
    chk("rst data", bus.rx_data, 32'h0);
    chk("rst datak", 32'(bus.rx_datak), 32'h0);
    chk("rst valid", 32'(bus.rx_valid), 32'h0);
    chk("rst drop", 32'(bus.drop_cnt), 32'h0);
    chk("rst width", 32'(bus.cur_width), 32'd2);
    reset_n = 1'b1;
    // 32b word
    drive(1, 8'h11, 1, 0);
    chk("w32 b0 valid", 32'(bus.rx_valid), 32'd0);
    drive(1, 8'h22, 0, 0);
    drive(1, 8'h33, 0, 0);
    chk("w32 b2 valid", 32'(bus.rx_valid), 32'd0);
    drive(1, 8'h44, 0, 0);
    chk_word("w32", 32'h44332211, 4'b0001);
    drive(0, 8'h00, 0, 0);
    chk("w32 idle valid", 32'(bus.rx_valid), 32'd0);
    chk("w32 hold data", bus.rx_data, 32'h44332211);
    // 16b with an idle gap
    bus.width_sel = 2'd1;
    drive(1, 8'hBC, 1, 0);
    chk("w16 cur_width", 32'(bus.cur_width), 32'd1);
    chk("w16 b0 valid", 32'(bus.rx_valid), 32'd0);
    drive(1, 8'hAA, 0, 0);
    chk_word("w16a", 32'h0000AABC, 4'b0001);
    drive(0, 8'h00, 0, 0);
    chk("w16 idle valid", 32'(bus.rx_valid), 32'd0);
    drive(1, 8'h01, 0, 0);
    chk("w16 b2 valid", 32'(bus.rx_valid), 32'd0);
    drive(1, 8'h02, 0, 0);
    chk_word("w16b", 32'h00000201, 4'b0000);
    // 8b streaming, K on the third byte
    bus.width_sel = 2'd0;
    drive(1, 8'hF0, 0, 0);
    chk_word("w8 0", 32'h000000F0, 4'b0000);
    chk("w8 cur_width", 32'(bus.cur_width), 32'd0);
    drive(1, 8'hF1, 0, 0);
    chk_word("w8 1", 32'h000000F1, 4'b0000);
    drive(1, 8'hF2, 1, 0);
    chk_word("w8 2", 32'h000000F2, 4'b0001);
    drive(1, 8'hF3, 0, 0);
    chk_word("w8 3", 32'h000000F3, 4'b0000);
    drive(1, 8'hF4, 0, 0);
    chk_word("w8 4", 32'h000000F4, 4'b0000);
    drive(0, 8'h00, 0, 0);
    chk("w8 idle valid", 32'(bus.rx_valid), 32'd0);
    // alignment drop with a symbol
    bus.width_sel = 2'd3;
    drive(1, 8'hA1, 0, 0);
    chk("w3 maps to 2", 32'(bus.cur_width), 32'd2);
    drive(1, 8'hA2, 0, 0);
    drive(1, 8'hB1, 0, 1);
    chk("align valid", 32'(bus.rx_valid), 32'd0);
    chk("align drop", 32'(bus.drop_cnt), 32'd1);
    drive(1, 8'hB2, 0, 0);
    drive(1, 8'hB3, 0, 0);
    chk("align b3 valid", 32'(bus.rx_valid), 32'd0);
    drive(1, 8'hB4, 1, 0);
    chk_word("align", 32'hB4B3B2B1, 4'b1000);
    // align at lane 0 is a plain accept
    drive(1, 8'h51, 0, 1);
    chk("align l0 drop", 32'(bus.drop_cnt), 32'd1);
    drive(1, 8'h52, 0, 0);
    drive(1, 8'h53, 0, 0);
    drive(1, 8'h54, 0, 0);
    chk_word("align l0", 32'h54535251, 4'b0000);
    // width change deferred until the word completes
    bus.width_sel = 2'd2;
    drive(1, 8'hC1, 0, 0);
    drive(1, 8'hC2, 0, 0);
    bus.width_sel = 2'd1;
    drive(1, 8'hC3, 0, 0);
    chk("wc mid width", 32'(bus.cur_width), 32'd2);
    chk("wc mid valid", 32'(bus.rx_valid), 32'd0);
    drive(1, 8'hC4, 0, 0);
    chk_word("wc 32b", 32'hC4C3C2C1, 4'b0000);
    drive(1, 8'hD1, 0, 0);
    chk("wc new width", 32'(bus.cur_width), 32'd1);
    drive(1, 8'hD2, 1, 0);
    chk_word("wc 16b", 32'h0000D2D1, 4'b0010);
    // align without a symbol discards the partial word
    bus.width_sel = 2'd2;
    drive(1, 8'hE1, 0, 0);
    drive(1, 8'hE2, 0, 0);
    drive(0, 8'h00, 0, 1);
    chk("idle align drop", 32'(bus.drop_cnt), 32'd2);
    chk("idle align valid", 32'(bus.rx_valid), 32'd0);
    drive(1, 8'h61, 0, 0);
    drive(1, 8'h62, 0, 0);
    drive(1, 8'h63, 0, 0);
    drive(1, 8'h64, 0, 0);
    chk_word("idle align", 32'h64636261, 4'b0000);
    // reset mid-word
    drive(1, 8'h71, 0, 0);
    drive(1, 8'h72, 0, 0);
    drive(1, 8'h73, 0, 0);
    reset_n = 1'b0;
    drive(0, 8'h00, 0, 0);
    chk("mid rst drop", 32'(bus.drop_cnt), 32'd0);
    chk("mid rst data", bus.rx_data, 32'h0);
    reset_n = 1'b1;
    drive(1, 8'h05, 0, 0);
    drive(1, 8'h06, 0, 0);
    drive(1, 8'h07, 0, 0);
    chk("mid rst b2 valid", 32'(bus.rx_valid), 32'd0);
    drive(1, 8'h08, 0, 0);
    chk_word("mid rst", 32'h08070605, 4'b0000);
    chk("mid rst drop2", 32'(bus.drop_cnt), 32'd0);
    // drop counter saturation
    for (int i = 0; i < 300; i++) begin
      drive(1, 8'h99, 0, 0);
      drive(0, 8'h00, 0, 1);
      if (i == 253) chk("drop 254", 32'(bus.drop_cnt), 32'd254);
    end
    chk("drop sat", 32'(bus.drop_cnt), 32'd255);
    chk("drop sat data", bus.rx_data, 32'h08070605);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
